// File: rtl/data_ram_pkg.sv
// Shared types and default sizes for the data RAM controller.
package data_ram_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DUMP  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/data_ram_array.sv
// Single-port synchronous RAM; the registered read returns the new data on a write (write-first).
module data_ram_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The array itself has no reset; the controller zero-fills it after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (we) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_controller.sv
// CPU data memory stage: zero-fill after reset, strobed CPU writes, registered reads.
// Define DATA_RAM_DUMP_EN to build the DUMP state and the DUMP_* image stream port.
module data_ram_controller
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  MAIN_CLOCK,
  input  logic                  RESET,
  input  logic                  CPU_CLOCK,
  input  logic [15:0]           CPU_ADDRESS,
  input  logic [DATA_WIDTH-1:0] CPU_DATA,
  input  logic                  CPU_WRITE_EN,
  input  logic                  PROCESS_FINISHED,
  output logic [DATA_WIDTH-1:0] DATA_FROM_RAM,
  output logic                  READY,
  output logic                  ADDR_ERROR,
`ifdef DATA_RAM_DUMP_EN
  output logic                  DUMP_VALID,
  input  logic                  DUMP_READY,
  output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
  output logic [DATA_WIDTH-1:0] DUMP_DATA,
  output logic                  DUMP_DONE,
`endif
  output logic [1:0]            fsm_state
);

  state_t                state, state_next;
  logic                  cpu_clk_q, pf_q, cpu_sel_q, addr_error;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  in_range, wr_stb, pf_rise, cpu_rd;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  assign in_range = (CPU_ADDRESS[15:ADDR_WIDTH] == '0);
  // CPU_CLOCK is only sampled; its low-to-high transition yields one write slot per CPU cycle.
  assign wr_stb   = CPU_CLOCK & ~cpu_clk_q;
  assign pf_rise  = PROCESS_FINISHED & ~pf_q;

`ifdef DATA_RAM_DUMP_EN
  // Valid/ready: a beat transfers on a cycle where DUMP_VALID and DUMP_READY are both high;
  // while DUMP_VALID is high and DUMP_READY low, DUMP_ADDR/DUMP_DATA hold and DUMP_VALID stays up.
  logic                  dump_valid, dump_done, dump_fire, dump_last;
  logic [ADDR_WIDTH-1:0] dump_idx, dump_fetch;

  assign dump_fire  = dump_valid & DUMP_READY;
  assign dump_last  = (dump_idx == '1);
  assign dump_fetch = dump_fire ? dump_idx + 1'b1 : dump_idx;

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_done  <= 1'b0;
    end else if (state == DUMP) begin
      if (!dump_valid) begin
        dump_valid <= 1'b1;
      end else if (dump_fire) begin
        if (dump_last) begin
          dump_valid <= 1'b0;
          dump_done  <= 1'b1;
        end else begin
          dump_idx <= dump_idx + 1'b1;
        end
      end
    end
  end

  assign DUMP_VALID = dump_valid;
  assign DUMP_ADDR  = dump_idx;
  assign DUMP_DATA  = dump_valid ? ram_rdata : '0;
  assign DUMP_DONE  = dump_done;
`endif

  always_comb begin
    state_next = state;
    ram_addr   = CPU_ADDRESS[ADDR_WIDTH-1:0];
    ram_we     = 1'b0;
    ram_wdata  = CPU_DATA;
    cpu_rd     = 1'b0;
    case (state)
      CLEAR: begin
        ram_addr  = clr_idx;
        ram_we    = 1'b1;
        ram_wdata = '0;
        if (clr_idx == '1) begin
          state_next = RUN;
        end
      end
      RUN: begin
        cpu_rd = in_range;
        ram_we = wr_stb & CPU_WRITE_EN & in_range & ~pf_rise;
        if (pf_rise) begin
`ifdef DATA_RAM_DUMP_EN
          state_next = DUMP;
`else
          state_next = HALT;
`endif
        end
      end
      DUMP: begin
`ifdef DATA_RAM_DUMP_EN
        ram_addr = dump_fetch;
        if (dump_fire && dump_last) begin
          state_next = HALT;
        end
`else
        state_next = HALT;
`endif
      end
      HALT: begin
        cpu_rd = in_range;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      cpu_clk_q  <= 1'b0;
      pf_q       <= 1'b0;
      cpu_sel_q  <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_clk_q <= CPU_CLOCK;
      pf_q      <= PROCESS_FINISHED;
      cpu_sel_q <= cpu_rd;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
      end
      if ((state == RUN || state == HALT) && !in_range) begin
        addr_error <= 1'b1;
      end
    end
  end

  data_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (MAIN_CLOCK),
    .reset(RESET),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Out-of-range reads and non-CPU port cycles present zero to the CPU.
  assign DATA_FROM_RAM = cpu_sel_q ? ram_rdata : '0;
  assign READY         = (state != CLEAR);
  assign ADDR_ERROR    = addr_error;
  assign fsm_state     = state;

endmodule

// File: tb/tb_data_ram_controller.sv
// Self-checking bench for data_ram_controller: vector table, scoreboard queue, multi-cycle sequences.
module tb_data_ram_controller;
  import data_ram_pkg::*;

  logic        main_clock = 1'b0;
  logic        reset;
  logic        cpu_clock;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data;
  logic        cpu_write_en;
  logic        process_finished;
  logic [7:0]  data_from_ram;
  logic        ready;
  logic        addr_error;
  logic [1:0]  fsm_state;
`ifdef DATA_RAM_DUMP_EN
  logic        dump_valid;
  logic        dump_ready;
  logic [7:0]  dump_addr;
  logic [7:0]  dump_data;
  logic        dump_done;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          strobe_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  model [256];

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs [14];

  data_ram_controller dut (
    .MAIN_CLOCK      (main_clock),
    .RESET           (reset),
    .CPU_CLOCK       (cpu_clock),
    .CPU_ADDRESS     (cpu_address),
    .CPU_DATA        (cpu_data),
    .CPU_WRITE_EN    (cpu_write_en),
    .PROCESS_FINISHED(process_finished),
    .DATA_FROM_RAM   (data_from_ram),
    .READY           (ready),
    .ADDR_ERROR      (addr_error),
`ifdef DATA_RAM_DUMP_EN
    .DUMP_VALID      (dump_valid),
    .DUMP_READY      (dump_ready),
    .DUMP_ADDR       (dump_addr),
    .DUMP_DATA       (dump_data),
    .DUMP_DONE       (dump_done),
`endif
    .fsm_state       (fsm_state)
  );

  // Clock and strobe monitor
  always #5 main_clock = ~main_clock;

  always @(posedge main_clock) begin
    if (dut.ram_we && fsm_state == RUN) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic tick();
    @(posedge main_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", name, data_from_ram);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(data_from_ram), 32'(e));
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    reset            = 1'b1;
    cpu_clock        = 1'b0;
    cpu_write_en     = 1'b0;
    process_finished = 1'b0;
    cpu_address      = '0;
    cpu_data         = '0;
`ifdef DATA_RAM_DUMP_EN
    dump_ready       = 1'b0;
`endif
    tick();
    tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", 32'(data_from_ram), 32'd0);
    check("rst_addr_error", 32'(addr_error), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(CLEAR));
`ifdef DATA_RAM_DUMP_EN
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_dump_done", 32'(dump_done), 32'd0);
    check("rst_dump_addr", 32'(dump_addr), 32'd0);
    check("rst_dump_data", 32'(dump_data), 32'd0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic wait_ready(input bit wr_during_clear);
    int n;
    n = 0;
    if (wr_during_clear) begin
      cpu_address  = 16'h0010;
      cpu_data     = 8'hFF;
      cpu_write_en = 1'b1;
    end
    while (!ready && n < 1000) begin
      if (wr_during_clear) cpu_clock = ~cpu_clock;
      if (n == 250) cpu_write_en = 1'b0;
      tick();
      n++;
    end
    cpu_write_en = 1'b0;
    cpu_clock    = 1'b0;
    cpu_address  = '0;
    check("clear_length", 32'(n), 32'd256);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] e, input string name);
    cpu_clock    = 1'b0;
    cpu_write_en = 1'b0;
    cpu_address  = a;
    exp_q.push_back(e);
    tick();
    sb_check(name);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int periods,
                           input logic [7:0] exp_rd, input string name);
    cpu_address  = a;
    cpu_data     = d;
    cpu_write_en = 1'b1;
    cpu_clock    = 1'b0;
    tick();
    for (int p = 0; p < periods; p++) begin
      cpu_clock = 1'b1;
      if (p == 0) exp_q.push_back(exp_rd);
      tick();
      if (p == 0) sb_check(name);
      cpu_clock = 1'b0;
      tick();
    end
    cpu_write_en = 1'b0;
  endtask

  initial begin
    int base;
    int n;
`ifdef DATA_RAM_DUMP_EN
    int beat;
    int ticks;
    int stall_left;
`endif

    vecs[0]  = '{1'b0, 16'h0000, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 16'h007F, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 16'h00FF, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 16'h0010, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 16'h0000, 8'h11, 8'h11};
    vecs[5]  = '{1'b1, 16'h00FF, 8'hEE, 8'hEE};
    vecs[6]  = '{1'b1, 16'h007F, 8'h5A, 8'h5A};
    vecs[7]  = '{1'b1, 16'h0003, 8'h3C, 8'h3C};
    vecs[8]  = '{1'b0, 16'h0000, 8'h00, 8'h11};
    vecs[9]  = '{1'b0, 16'h00FF, 8'h00, 8'hEE};
    vecs[10] = '{1'b0, 16'h007F, 8'h00, 8'h5A};
    vecs[11] = '{1'b0, 16'h0042, 8'h00, 8'hA5};
    vecs[12] = '{1'b0, 16'h0080, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 16'h0003, 8'h00, 8'h3C};

    // Reset, zero fill with a write attempt to 0x10 during the clear
    do_reset();
    wait_ready(1'b1);
    check("run_state", 32'(fsm_state), 32'(RUN));

    // Three CPU periods of writes to 0x42: one strobe each, write-first readback
    base = strobe_cnt;
    cpu_write(16'h0042, 8'hA5, 3, 8'hA5, "wr42_first");
    model[8'h42] = 8'hA5;
    check("wr42_strobes", 32'(strobe_cnt - base), 32'd3);
    check("no_addr_error", 32'(addr_error), 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        cpu_write(vecs[i].addr, vecs[i].data, 1, vecs[i].exp, $sformatf("vec%0d_wr", i));
        model[vecs[i].addr[7:0]] = vecs[i].data;
      end else begin
        cpu_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rd", i));
      end
    end

    // Out-of-range write is dropped and flagged
    cpu_write(16'h0142, 8'h55, 1, 8'h00, "oor_wr");
    check("oor_flag", 32'(addr_error), 32'd1);
    cpu_read(16'h0042, 8'hA5, "oor_alias_unchanged");
    check("oor_flag_sticky", 32'(addr_error), 32'd1);
    cpu_read(16'h0142, 8'h00, "oor_rd");

`ifdef DATA_RAM_DUMP_EN
    // Image dump with a 5-cycle stall on beat 3
    for (int i = 0; i < 256; i++) exp_q.push_back(model[i]);
    stall_left       = 5;
    beat             = 0;
    ticks            = 0;
    dump_ready       = 1'b1;
    cpu_address      = 16'h0000;
    process_finished = 1'b1;
    while (!dump_done && ticks < 600) begin
      tick();
      ticks++;
      if (dump_valid) begin
        if (dump_addr == 8'd3 && stall_left > 0) begin
          if (stall_left < 5) begin
            check("stall_addr", 32'(dump_addr), 32'd3);
            check("stall_data", 32'(dump_data), 32'h3C);
          end
          dump_ready = 1'b0;
          stall_left--;
        end else begin
          dump_ready = 1'b1;
          check("beat_addr", 32'(dump_addr), 32'(beat));
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_data: extra beat %0d, got 0x%0h", beat, dump_data);
          end else begin
            check("beat_data", 32'(dump_data), 32'(exp_q.pop_front()));
          end
          beat++;
        end
      end
    end
    check("dump_beats", 32'(beat), 32'd256);
    check("dump_cycles", 32'(ticks), 32'd263);
    check("dump_valid_end", 32'(dump_valid), 32'd0);
    check("dump_done_end", 32'(dump_done), 32'd1);
`else
    process_finished = 1'b1;
    tick();
    tick();
`endif
    check("halt_state", 32'(fsm_state), 32'(HALT));

    // Array is frozen in HALT; reads still served
    cpu_write(16'h0042, 8'h99, 1, 8'hA5, "halt_wr_ignored");
    cpu_read(16'h0042, 8'hA5, "halt_rd");

    // Reset clears the sticky flag; a reset mid-clear restarts the full clear
    do_reset();
    for (int i = 0; i < 100; i++) tick();
    check("midclear_ready", 32'(ready), 32'd0);
    do_reset();
    wait_ready(1'b0);
    cpu_read(16'h0042, 8'h00, "after_reclear_rd");

`ifdef DATA_RAM_DUMP_EN
    // Reset at dump beat 100
    cpu_write(16'h0064, 8'h77, 1, 8'h77, "pre_dump_wr");
    dump_ready       = 1'b1;
    process_finished = 1'b1;
    n = 0;
    while (!(dump_valid && dump_addr == 8'd100) && n < 400) begin
      tick();
      n++;
    end
    check("reach_beat100", 32'(dump_addr), 32'd100);
    check("beat100_data", 32'(dump_data), 32'h77);
    reset = 1'b1;
    tick();
    check("middump_valid", 32'(dump_valid), 32'd0);
    check("middump_done", 32'(dump_done), 32'd0);
    check("middump_ready", 32'(ready), 32'd0);
    do_reset();
    wait_ready(1'b0);
    cpu_read(16'h0064, 8'h00, "after_middump_rd");
`else
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_ram_controller.md
# data_ram_controller

Data memory stage downstream of the CPU: accepts the CPU's address/data/write-enable outputs and returns read data on `DATA_FROM_RAM`. Runs on the board `MAIN_CLOCK` and converts the CPU's `CPU_CLOCK` into a single write strobe per CPU cycle. Zero-fills the array after reset. When the program raises `PROCESS_FINISHED`, it can stream the full memory image out over a valid/ready port for inspection.

## Interface
- `ADDR_WIDTH`, 8 — array address bits; `DEPTH = 2**ADDR_WIDTH` bytes.
- `DATA_WIDTH`, 8 — word width; matches the CPU data path.
- `MAIN_CLOCK`  in  1  — the single clock; all state updates on its rising edge.
- `RESET`  in  1  — synchronous, active-high.
- `CPU_CLOCK`  in  1  — CPU tick, sampled as data (never used as a clock).
- `CPU_ADDRESS`  in  16  — CPU address register.
- `CPU_DATA`  in  DATA_WIDTH  — write data.
- `CPU_WRITE_EN`  in  1  — write request for the current CPU cycle.
- `PROCESS_FINISHED`  in  1  — CPU halt indication.
- `DATA_FROM_RAM`  out  DATA_WIDTH  — registered read data to the CPU.
- `READY`  out  1  — clear sequence complete; the top level holds the CPU until this is high.
- `ADDR_ERROR`  out  1  — sticky flag: an out-of-range access occurred.
- `DUMP_VALID`  out  1  — dump beat valid (only with the macro).
- `DUMP_READY`  in  1  — dump consumer ready (only with the macro).
- `DUMP_ADDR`  out  ADDR_WIDTH  — address of the current dump beat (only with the macro).
- `DUMP_DATA`  out  DATA_WIDTH  — data of the current dump beat (only with the macro).
- `DUMP_DONE`  out  1  — sticky; full image sent (only with the macro).

## Operation
- FSM states and transitions:
  - `CLEAR` (entered on reset) → `RUN` → `DUMP` → `HALT`.
  - Without the macro: `RUN` → `HALT` on `PROCESS_FINISHED`.
- **`CLEAR`:**
  - Writes 0 to address `clr_idx`, one address per cycle, starting at 0.
  - After address `DEPTH-1`, goes to `RUN`.
  - CPU writes are ignored in this state.
- **Write strobe:** `wr_stb = CPU_CLOCK & ~cpu_clk_q`, where `cpu_clk_q` is `CPU_CLOCK` registered on `MAIN_CLOCK`.
  - Gives exactly one strobe per CPU_CLOCK period.
  - In `RUN`, the array is written when `wr_stb & CPU_WRITE_EN & in_range`.
- **Range check:** `in_range = (CPU_ADDRESS[15:ADDR_WIDTH] == 0)`.
  - Out-of-range write: dropped; sets `ADDR_ERROR`.
  - Out-of-range read: returns 0; sets `ADDR_ERROR`.
- **Read:** every cycle, `DATA_FROM_RAM <= mem[CPU_ADDRESS[ADDR_WIDTH-1:0]]`.
  - On a cycle with a simultaneous write to the same address, the new data is returned (write-first).
- **Halt entry:** on a rising edge of `PROCESS_FINISHED` in `RUN`, go to `DUMP` (macro on) or `HALT` (macro off).
  - No further CPU writes are accepted after this point.
- **`DUMP`:**
  - `dump_idx` starts at 0.
  - Each beat presents `DUMP_ADDR = dump_idx` and `DUMP_DATA = mem[dump_idx]` with `DUMP_VALID = 1`.
  - The beat advances only on `DUMP_VALID & DUMP_READY`.
  - `DUMP_ADDR`/`DUMP_DATA` hold stable while stalled.
  - After the beat at `DEPTH-1` is accepted: `DUMP_VALID` goes to 0, `DUMP_DONE` goes to 1, state goes to `HALT`.
- **`HALT`:** the array is frozen; reads continue to be served.
- **Reset mid-operation:** reset from any state (including mid-dump or mid-clear) aborts and restarts `CLEAR` from index 0.

## Timing
- Reset values: `DATA_FROM_RAM=0`, `READY=0`, `ADDR_ERROR=0`, `DUMP_VALID=0`, `DUMP_ADDR=0`, `DUMP_DATA=0`, `DUMP_DONE=0`, `cpu_clk_q=0`.
- Clear length: `READY` rises `DEPTH` cycles after the cycle that deasserts reset (256 cycles at the default).
- Read latency: 1 `MAIN_CLOCK` cycle, which is inside the 2-cycle CPU period, so the CPU always latches settled data.
- Write commit: at the first `MAIN_CLOCK` edge that samples `CPU_CLOCK` high after it was sampled low.
- Dump: `DUMP_DATA` is registered; the first beat is valid 1 cycle after entering `DUMP`.
  - Throughput: 1 beat/cycle when `DUMP_READY` is held high.
  - Full dump: `DEPTH + 1` cycles.

## Configuration
- Macro: `DATA_RAM_DUMP_EN`.
- Defined: the `DUMP` state and the `DUMP_*` ports exist, with the behaviour described above.
- Undefined:
  - The `DUMP_*` ports are absent.
  - `PROCESS_FINISHED` moves `RUN` directly to `HALT`.
  - No dump counter is built.

## Structure
- Package `data_ram_pkg` holds:
  - the state enum (`CLEAR`, `RUN`, `DUMP`, `HALT`);
  - the default `ADDR_WIDTH` and `DATA_WIDTH` constants.
- Sub-module `data_ram_array`: single-port synchronous RAM with write-first read.
  - The controller muxes the clear, CPU and dump accesses onto this one port.
  - Access is exclusive by state, so no arbitration is needed.

## Test plan
- **Reset then idle:** `READY=0` for 256 cycles, then 1; reads at addresses 0x00, 0x7F and 0xFF all return 0.
- **CPU write/read:** `CPU_CLOCK` toggling every cycle, `CPU_WRITE_EN=1`, `CPU_ADDRESS=0x0042`, `CPU_DATA=0xA5`, held for 3 CPU periods → exactly 3 write strobes; a later read of 0x0042 returns 0xA5 with 1-cycle latency.
- **Out of range:** write 0x55 to `CPU_ADDRESS=0x0142` → `ADDR_ERROR=1` and stays 1; address 0x42 is unchanged; a read of 0x0142 returns 0.
- **Write during clear:** `CPU_WRITE_EN=1` at address 0x10 with data 0xFF while `READY=0` → address 0x10 reads 0 after `READY` rises.
- **Dump with backpressure** (macro on): preload address 0x03 with 0x3C, raise `PROCESS_FINISHED`, hold `DUMP_READY=0` for 5 cycles at beat 3 → `DUMP_ADDR=3` and `DUMP_DATA=0x3C` stay stable; all 256 beats arrive in order; then `DUMP_DONE=1`.
- **Reset mid-dump:** assert `RESET` at beat 100 → `DUMP_VALID=0`, `DUMP_DONE=0`, `READY=0`, and a full clear restarts.
